// File: rtl/vc_alloc_ctrl.sv
// Victim-cache write-side controller: picks a way, writes back dirty victims, drives tag-store write/clear ports.
// Latency: accept->wr_en 1 cycle clean, 2+ack wait dirty; evict_rdy_o low outside IDLE and while flush is requested.
module vc_alloc_ctrl #(
    parameter int AWT         = 32,
    parameter int WORD_SEL    = 4,
    parameter int TAG_WT_VC   = AWT - WORD_SEL - 2,
    parameter int VC_WAYS_EXP = 2,
    parameter int VC_WAYS     = 2 ** VC_WAYS_EXP
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   evict_vld_i,
    output logic                   evict_rdy_o,
    input  logic [TAG_WT_VC-1:0]   evict_tag_i,
    input  logic                   evict_dirty_i,
    input  logic                   promote_i,
    input  logic [VC_WAYS_EXP-1:0] promote_way_i,
    input  logic                   flush_req_i,
    output logic                   flush_done_o,
    input  logic [VC_WAYS-1:0]     valid_i,
    output logic                   wr_en_o,
    output logic [VC_WAYS_EXP-1:0] wr_way_o,
    output logic [TAG_WT_VC-1:0]   wr_tag_o,
    output logic                   clear_all_o,
    output logic                   clear_line_o,
    output logic [VC_WAYS_EXP-1:0] clear_way_o,
    output logic                   wb_req_o,
    input  logic                   wb_ack_i,
    output logic [VC_WAYS_EXP-1:0] wb_way_o,
    output logic [TAG_WT_VC-1:0]   wb_tag_o,
    output logic [VC_WAYS-1:0]     dirty_o
);
    typedef enum logic [2:0] {IDLE, WB, INSERT, FL_SCAN, FL_WB, FL_CLR, FL_DONE} state_t;

    localparam logic [VC_WAYS_EXP-1:0] LAST_WAY = VC_WAYS_EXP'(VC_WAYS - 1);

    state_t                 state_q, state_d;
    logic [VC_WAYS_EXP-1:0] rr_q, rr_d;
    logic [VC_WAYS_EXP-1:0] victim_q, victim_d;
    logic [VC_WAYS_EXP-1:0] idx_q, idx_d;
    logic                   repl_q, repl_d;
    logic [TAG_WT_VC-1:0]   tag_q, tag_d;
    logic                   ldirty_q, ldirty_d;
    logic [VC_WAYS-1:0]     dirty_q, dirty_d;
    logic [TAG_WT_VC-1:0]   shadow_q [VC_WAYS];
    logic                   clear_line_q;
    logic [VC_WAYS_EXP-1:0] clear_way_q;

    logic                   free_found;
    logic [VC_WAYS_EXP-1:0] free_way;
    logic                   accept;
    logic                   do_write;

    // Descending scan so the lowest free index is the one left standing.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int i = VC_WAYS - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_found = 1'b1;
                free_way   = VC_WAYS_EXP'(i);
            end
        end
    end

    assign evict_rdy_o  = (state_q == IDLE) && !flush_req_i && rst_i;
    assign accept       = evict_vld_i && evict_rdy_o;
    assign do_write     = (state_q == INSERT) && !clear_line_q;

    assign wr_en_o      = do_write;
    assign wr_way_o     = victim_q;
    assign wr_tag_o     = tag_q;
    assign wb_req_o     = (state_q == WB) || (state_q == FL_WB);
    assign wb_way_o     = (state_q == FL_WB) ? idx_q : victim_q;
    assign wb_tag_o     = shadow_q[wb_way_o];
    assign clear_all_o  = (state_q == FL_CLR);
    assign flush_done_o = (state_q == FL_DONE);
    assign clear_line_o = clear_line_q;
    assign clear_way_o  = clear_way_q;
    assign dirty_o      = dirty_q;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        victim_d = victim_q;
        idx_d    = idx_q;
        repl_d   = repl_q;
        tag_d    = tag_q;
        ldirty_d = ldirty_q;
        unique case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    idx_d   = '0;
                    state_d = FL_SCAN;
                end else if (accept) begin
                    tag_d    = evict_tag_i;
                    ldirty_d = evict_dirty_i;
                    victim_d = free_found ? free_way : rr_q;
                    repl_d   = !free_found;
                    state_d  = (!free_found && dirty_q[rr_q]) ? WB : INSERT;
                end
            end
            WB: if (wb_ack_i) state_d = INSERT;
            INSERT: begin
                if (!clear_line_q) begin
                    if (repl_q) rr_d = rr_q + 1'b1;
                    state_d = IDLE;
                end
            end
            FL_SCAN: begin
                if (valid_i[idx_q] && dirty_q[idx_q]) state_d = FL_WB;
                else if (idx_q == LAST_WAY)           state_d = FL_CLR;
                else                                  idx_d   = idx_q + 1'b1;
            end
            FL_WB: begin
                if (wb_ack_i) begin
                    if (idx_q == LAST_WAY) begin
                        state_d = FL_CLR;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FL_SCAN;
                    end
                end
            end
            FL_CLR: begin
                rr_d    = '0;
                state_d = FL_DONE;
            end
            FL_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Promote is applied last so its dirty clear overrides insert and flush updates.
    always_comb begin
        dirty_d = dirty_q;
        if (do_write)                        dirty_d[victim_q]      = ldirty_q;
        if ((state_q == FL_WB) && wb_ack_i)  dirty_d[idx_q]         = 1'b0;
        if (state_q == FL_CLR)               dirty_d                = '0;
        if (promote_i)                       dirty_d[promote_way_i] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            victim_q     <= '0;
            idx_q        <= '0;
            repl_q       <= 1'b0;
            tag_q        <= '0;
            ldirty_q     <= 1'b0;
            dirty_q      <= '0;
            clear_line_q <= 1'b0;
            clear_way_q  <= '0;
            for (int i = 0; i < VC_WAYS; i++) shadow_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            victim_q     <= victim_d;
            idx_q        <= idx_d;
            repl_q       <= repl_d;
            tag_q        <= tag_d;
            ldirty_q     <= ldirty_d;
            dirty_q      <= dirty_d;
            clear_line_q <= promote_i;
            clear_way_q  <= promote_way_i;
            if (do_write) shadow_q[victim_q] <= tag_q;
        end
    end
endmodule

// File: tb/tb_vc_alloc_ctrl.sv
// Bench for vc_alloc_ctrl: behavioural tag store, scoreboard queues for writes and writebacks.
module tb_vc_alloc_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        evict_vld_i = 1'b0;
    logic        evict_rdy_o;
    logic [25:0] evict_tag_i = '0;
    logic        evict_dirty_i = 1'b0;
    logic        promote_i = 1'b0;
    logic [1:0]  promote_way_i = '0;
    logic        flush_req_i = 1'b0;
    logic        flush_done_o;
    logic [3:0]  valid_i;
    logic        wr_en_o;
    logic [1:0]  wr_way_o;
    logic [25:0] wr_tag_o;
    logic        clear_all_o;
    logic        clear_line_o;
    logic [1:0]  clear_way_o;
    logic        wb_req_o;
    logic        wb_ack_i = 1'b0;
    logic [1:0]  wb_way_o;
    logic [25:0] wb_tag_o;
    logic [3:0]  dirty_o;

    vc_alloc_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .evict_vld_i(evict_vld_i), .evict_rdy_o(evict_rdy_o),
        .evict_tag_i(evict_tag_i), .evict_dirty_i(evict_dirty_i),
        .promote_i(promote_i), .promote_way_i(promote_way_i),
        .flush_req_i(flush_req_i), .flush_done_o(flush_done_o),
        .valid_i(valid_i),
        .wr_en_o(wr_en_o), .wr_way_o(wr_way_o), .wr_tag_o(wr_tag_o),
        .clear_all_o(clear_all_o), .clear_line_o(clear_line_o), .clear_way_o(clear_way_o),
        .wb_req_o(wb_req_o), .wb_ack_i(wb_ack_i), .wb_way_o(wb_way_o), .wb_tag_o(wb_tag_o),
        .dirty_o(dirty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  way;
        logic [25:0] tag;
        bit          wb;
        int          t0;
        int          extra;
    } wr_ent_t;
    typedef struct {
        logic [1:0]  way;
        logic [25:0] tag;
    } wb_ent_t;

    wr_ent_t     wr_q[$];
    wb_ent_t     wb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          held = 0;
    int          last_ack = 0;
    logic [3:0]  tb_valid = '0;
    logic [3:0]  m_dirty = '0;
    logic [1:0]  m_rr = '0;
    logic [25:0] m_shadow [4];

    assign valid_i = tb_valid;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Tag store: clear beats write, shares the controller's reset.
    always @(posedge clk_i) begin
        if (!rst_i)             tb_valid <= '0;
        else if (clear_all_o)   tb_valid <= '0;
        else if (clear_line_o)  tb_valid[clear_way_o] <= 1'b0;
        else if (wr_en_o)       tb_valid[wr_way_o] <= 1'b1;
    end

    always @(negedge clk_i) begin
        if (wr_en_o) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexp", wr_en_o, 0);
            end else begin
                wr_ent_t e;
                e = wr_q.pop_front();
                chk("wr_way", wr_way_o, e.way);
                chk("wr_tag", wr_tag_o, e.tag);
                chk("wr_lat", cyc, (e.wb ? last_ack : e.t0) + 1 + e.extra);
                chk("wr_vs_clr", clear_line_o, 0);
            end
        end
        if (wb_req_o) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexp", wb_req_o, 0);
                wb_ack_i = 1'b0;
            end else begin
                chk("wb_way", wb_way_o, wb_q[0].way);
                chk("wb_tag", wb_tag_o, wb_q[0].tag);
                held++;
                if (wait_cnt >= ack_delay) begin
                    wb_ack_i = 1'b1;
                    void'(wb_q.pop_front());
                    chk("wb_held", held, ack_delay + 1);
                    last_ack = cyc;
                    held = 0;
                    wait_cnt = 0;
                end else begin
                    wb_ack_i = 1'b0;
                    wait_cnt++;
                end
            end
        end else begin
            wb_ack_i = 1'b0;
            wait_cnt = 0;
            held = 0;
        end
    end

    task automatic clear_model();
        wr_q.delete();
        wb_q.delete();
        m_dirty = '0;
        m_rr = '0;
        for (int i = 0; i < 4; i++) m_shadow[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        evict_vld_i = 1'b0;
        promote_i = 1'b0;
        flush_req_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_rdy", evict_rdy_o, 0);
        clear_model();
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic evict(input logic [25:0] tag, input bit d, input bit prom, input logic [1:0] pway);
        int n = 0;
        bit found = 0;
        bit repl;
        bit wbf;
        logic [1:0] v = '0;
        wr_ent_t e;
        while (!evict_rdy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!evict_rdy_o) begin
            chk("evict_rdy_timeout", evict_rdy_o, 1);
            return;
        end
        for (int i = 3; i >= 0; i--) if (!tb_valid[i]) begin found = 1; v = 2'(i); end
        repl = !found;
        if (repl) v = m_rr;
        wbf = repl && m_dirty[v];
        if (wbf) wb_q.push_back('{way: v, tag: m_shadow[v]});
        e = '{way: v, tag: tag, wb: wbf, t0: cyc, extra: (prom ? 1 : 0)};
        wr_q.push_back(e);
        m_shadow[v] = tag;
        m_dirty[v] = d;
        if (repl) m_rr = m_rr + 2'd1;
        if (prom) m_dirty[pway] = 1'b0;
        evict_vld_i = 1'b1;
        evict_tag_i = tag;
        evict_dirty_i = d;
        promote_i = prom;
        promote_way_i = pway;
        @(negedge clk_i);
        evict_vld_i = 1'b0;
        promote_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!((wr_q.size() == 0) && (wb_q.size() == 0) && evict_rdy_o) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) chk(tag, wr_q.size() + wb_q.size(), 0);
        @(negedge clk_i);
    endtask

    initial begin
        int n;
        int clr_cnt;
        int clr_cyc;
        int done_cyc;
        bit rdy_seen;
        clear_model();

        // Reset values
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_wb_req", wb_req_o, 0);
        chk("rst_clr_all", clear_all_o, 0);
        chk("rst_clr_line", clear_line_o, 0);
        chk("rst_done", flush_done_o, 0);
        chk("rst_dirty", dirty_o, 0);
        chk("rst_rdy0", evict_rdy_o, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rdy_after_rst", evict_rdy_o, 1);

        // Free ways fill in order, then round robin wraps
        for (int i = 0; i < 4; i++) evict(26'h100 + 26'(i), 1'b0, 1'b0, 2'd0);
        wait_idle("fill_timeout");
        chk("fill_valid", valid_i, 4'hf);
        for (int i = 0; i < 5; i++) evict(26'h200 + 26'(i), 1'b0, 1'b0, 2'd0);
        wait_idle("rr_timeout");
        chk("rr_dirty", dirty_o, 0);

        // Dirty victim writeback with delayed ack
        do_reset();
        evict(26'h104, 1'b1, 1'b0, 2'd0);
        for (int i = 1; i < 4; i++) evict(26'h100 + 26'(i), 1'b0, 1'b0, 2'd0);
        wait_idle("wbset_timeout");
        chk("wbset_dirty", dirty_o, 4'b0001);
        ack_delay = 3;
        evict(26'h300, 1'b1, 1'b0, 2'd0);
        wait_idle("wb_timeout");
        chk("wb_dirty", dirty_o, m_dirty);
        evict(26'h301, 1'b0, 1'b0, 2'd0);
        wait_idle("wb2_timeout");
        chk("wb2_dirty", dirty_o, m_dirty);

        // Promote collides with insert
        do_reset();
        evict(26'h401, 1'b1, 1'b0, 2'd0);
        evict(26'h402, 1'b0, 1'b0, 2'd0);
        evict(26'h403, 1'b1, 1'b0, 2'd0);
        wait_idle("prset_timeout");
        promote_i = 1'b1;
        promote_way_i = 2'd0;
        @(negedge clk_i);
        promote_i = 1'b0;
        m_dirty[0] = 1'b0;
        chk("prom_clr_line", clear_line_o, 1);
        chk("prom_clr_way", clear_way_o, 0);
        @(negedge clk_i);
        chk("prom_dirty", dirty_o, 4'b0100);
        chk("prom_clr_off", clear_line_o, 0);
        evict(26'h500, 1'b1, 1'b1, 2'd2);
        chk("coll_clr_line", clear_line_o, 1);
        chk("coll_clr_way", clear_way_o, 2);
        chk("coll_wr_en", wr_en_o, 0);
        wait_idle("coll_timeout");
        chk("coll_dirty", dirty_o, 4'b0001);

        // Flush with two dirty lines
        do_reset();
        evict(26'h601, 1'b0, 1'b0, 2'd0);
        evict(26'h602, 1'b1, 1'b0, 2'd0);
        evict(26'h603, 1'b0, 1'b0, 2'd0);
        evict(26'h604, 1'b1, 1'b0, 2'd0);
        wait_idle("flset_timeout");
        chk("flset_dirty", dirty_o, 4'b1010);
        ack_delay = 1;
        wb_q.push_back('{way: 2'd1, tag: 26'h602});
        wb_q.push_back('{way: 2'd3, tag: 26'h604});
        flush_req_i = 1'b1;
        n = 0; clr_cnt = 0; clr_cyc = 0; done_cyc = -1; rdy_seen = 0;
        while (n < 100) begin
            @(negedge clk_i);
            n++;
            if (evict_rdy_o) rdy_seen = 1;
            if (clear_all_o) begin clr_cnt++; clr_cyc = cyc; end
            if (flush_done_o) begin done_cyc = cyc; flush_req_i = 1'b0; break; end
        end
        chk("fl_done_seen", (done_cyc >= 0), 1);
        chk("fl_clr_cnt", clr_cnt, 1);
        chk("fl_done_gap", done_cyc - clr_cyc, 1);
        chk("fl_rdy_low", rdy_seen, 0);
        chk("fl_wb_left", wb_q.size(), 0);
        chk("fl_dirty", dirty_o, 0);
        m_dirty = '0;
        m_rr = '0;
        @(negedge clk_i);
        chk("fl_done_pulse", flush_done_o, 0);
        chk("fl_rdy_back", evict_rdy_o, 1);
        chk("fl_valid", valid_i, 0);

        // Reset during writeback
        do_reset();
        evict(26'h701, 1'b1, 1'b0, 2'd0);
        for (int i = 1; i < 4; i++) evict(26'h701 + 26'(i), 1'b0, 1'b0, 2'd0);
        wait_idle("rwset_timeout");
        ack_delay = 1000;
        evict(26'h800, 1'b0, 1'b0, 2'd0);
        n = 0;
        while (!wb_req_o && n < 20) begin @(negedge clk_i); n++; end
        chk("rw_wb_seen", wb_req_o, 1);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rw_wb_drop", wb_req_o, 0);
        chk("rw_dirty", dirty_o, 0);
        chk("rw_rdy_rst", evict_rdy_o, 0);
        clear_model();
        ack_delay = 0;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rw_rdy_back", evict_rdy_o, 1);
        chk("rw_wr_en", wr_en_o, 0);

        chk("end_wr_q", wr_q.size(), 0);
        chk("end_wb_q", wb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
